// File: rtl/snake_walker.sv
// rtl/snake_walker.sv - walks a snake body stored in an external direction ring and probes one cell
// Define SNAKE_WALKER_WRAP_EN for toroidal stepping; otherwise o_oob flags off-grid positions.
module snake_walker #(
   parameter int DEPTH  = 220,
   parameter int LEN_W  = 8,
   parameter int GRID_W = 16,
   parameter int GRID_H = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       i_dir,
   output logic [1:0]       o_dir,
   input  logic             i_start,
   input  logic [3:0]       i_head_x,
   input  logic [3:0]       i_head_y,
   input  logic [LEN_W-1:0] i_len,
   input  logic [3:0]       i_query_x,
   input  logic [3:0]       i_query_y,
   input  logic             i_wr,
   input  logic [1:0]       i_wr_dir,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_hit,
`ifndef SNAKE_WALKER_WRAP_EN
   output logic             o_oob,
`endif
   output logic [LEN_W-1:0] o_hit_idx
);

   localparam int PH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_WALK, S_DONE} state_t;

   state_t           r_state;
   logic [PH_W-1:0]  r_phase;
   logic             r_wr_armed;
   logic [1:0]       r_wr_dir;
   logic [3:0]       r_pos_x;
   logic [3:0]       r_pos_y;
   logic [3:0]       r_qx;
   logic [3:0]       r_qy;
   logic [LEN_W-1:0] r_k;
   logic [LEN_W-1:0] r_last;
   logic             r_busy;
   logic             r_done;
   logic             r_hit;
   logic [LEN_W-1:0] r_hit_idx;

   logic             w_wr_now;
   logic             w_match;
   logic [LEN_W-1:0] w_last;
   logic [3:0]       w_nx;
   logic [3:0]       w_ny;

   // A pending head turn replaces segment 0 as it passes back into the ring.
   assign w_wr_now = r_wr_armed && (r_phase == '0);
   assign o_dir    = w_wr_now ? r_wr_dir : i_dir;
   assign w_match  = (r_pos_x == r_qx) && (r_pos_y == r_qy);

   always_comb begin
      w_last = i_len - LEN_W'(1);
      if (i_len == '0)
         w_last = '0;
      else if (32'(i_len) > DEPTH)
         w_last = LEN_W'(DEPTH - 1);
   end

`ifdef SNAKE_WALKER_WRAP_EN
   localparam logic [3:0] XMAX = 4'(GRID_W - 1);
   localparam logic [3:0] YMAX = 4'(GRID_H - 1);

   always_comb begin
      w_nx = r_pos_x;
      w_ny = r_pos_y;
      case (o_dir)
         2'd0: w_nx = (r_pos_x == XMAX) ? 4'd0 : r_pos_x + 4'd1;
         2'd1: w_ny = (r_pos_y == YMAX) ? 4'd0 : r_pos_y + 4'd1;
         2'd2: w_nx = (r_pos_x == 4'd0) ? XMAX : r_pos_x - 4'd1;
         default: w_ny = (r_pos_y == 4'd0) ? YMAX : r_pos_y - 4'd1;
      endcase
   end
`else
   localparam logic [4:0] GW5 = 5'(GRID_W);
   localparam logic [4:0] GH5 = 5'(GRID_H);

   logic r_oob;
   logic w_out;

   assign w_out = ({1'b0, r_pos_x} >= GW5) || ({1'b0, r_pos_y} >= GH5);
   assign o_oob = r_oob;

   always_comb begin
      w_nx = r_pos_x;
      w_ny = r_pos_y;
      case (o_dir)
         2'd0: w_nx = r_pos_x + 4'd1;
         2'd1: w_ny = r_pos_y + 4'd1;
         2'd2: w_nx = r_pos_x - 4'd1;
         default: w_ny = r_pos_y - 4'd1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_oob <= 1'b0;
      else if (r_state == S_IDLE && i_start)
         r_oob <= 1'b0;
      else if (r_state == S_WALK && w_out)
         r_oob <= 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= '0;
         r_wr_armed <= 1'b0;
         r_wr_dir   <= 2'd0;
      end else begin
         r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
         if (i_wr) begin
            r_wr_armed <= 1'b1;
            r_wr_dir   <= i_wr_dir;
         end else if (w_wr_now) begin
            r_wr_armed <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_pos_x   <= '0;
         r_pos_y   <= '0;
         r_qx      <= '0;
         r_qy      <= '0;
         r_k       <= '0;
         r_last    <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hit     <= 1'b0;
         r_hit_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_pos_x   <= i_head_x;
                  r_pos_y   <= i_head_y;
                  r_qx      <= i_query_x;
                  r_qy      <= i_query_y;
                  r_last    <= w_last;
                  r_busy    <= 1'b1;
                  r_hit     <= 1'b0;
                  r_hit_idx <= '0;
                  r_state   <= S_ALIGN;
               end
            end
            S_ALIGN: begin
               // Leave on the last phase so the first WALK cycle sees segment 0.
               if (r_phase == PH_LAST) begin
                  r_k     <= '0;
                  r_state <= S_WALK;
               end
            end
            S_WALK: begin
               if (w_match && !r_hit) begin
                  r_hit     <= 1'b1;
                  r_hit_idx <= r_k;
               end
               r_pos_x <= w_nx;
               r_pos_y <= w_ny;
               r_k     <= r_k + LEN_W'(1);
               if (r_k == r_last) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_hit     = r_hit;
   assign o_hit_idx = r_hit_idx;

endmodule

// File: tb/tb_snake_walker.sv
// tb/tb_snake_walker.sv - directed bench for snake_walker with a behavioural direction ring
module tb_snake_walker;

   localparam int DEPTH = 220;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] i_dir;
   logic [1:0] o_dir;
   logic       i_start;
   logic [3:0] i_head_x, i_head_y, i_query_x, i_query_y;
   logic [7:0] i_len;
   logic       i_wr;
   logic [1:0] i_wr_dir;
   logic       o_busy, o_done, o_hit;
   logic [7:0] o_hit_idx;
`ifndef SNAKE_WALKER_WRAP_EN
   logic       o_oob;
`endif

   logic [1:0] ring [0:DEPTH-1];
   logic       fill_en;
   logic [1:0] fill_val;
   int         cyc;
   int         n_checks = 0;
   int         n_fail = 0;

   snake_walker dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_dir     (i_dir),
      .o_dir     (o_dir),
      .i_start   (i_start),
      .i_head_x  (i_head_x),
      .i_head_y  (i_head_y),
      .i_len     (i_len),
      .i_query_x (i_query_x),
      .i_query_y (i_query_y),
      .i_wr      (i_wr),
      .i_wr_dir  (i_wr_dir),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_hit     (o_hit),
`ifndef SNAKE_WALKER_WRAP_EN
      .o_oob     (o_oob),
`endif
      .o_hit_idx (o_hit_idx)
   );

   always #5 clk = ~clk;

   // External DEPTH-deep shift register: o_dir enters, i_dir leaves.
   always @(posedge clk) begin
      if (fill_en) begin
         for (int i = 0; i < DEPTH; i++) ring[i] <= fill_val;
      end else begin
         for (int i = DEPTH - 1; i > 0; i--) ring[i] <= ring[i-1];
         ring[0] <= o_dir;
      end
   end
   assign i_dir = ring[DEPTH-1];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int count_val(input logic [1:0] v);
      int c = 0;
      for (int i = 0; i < DEPTH; i++) if (ring[i] === v) c++;
      return c;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic fill_ring(input logic [1:0] v);
      fill_en = 1'b1; fill_val = v;
      step();
      fill_en = 1'b0;
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      while ((cyc % DEPTH) != p && n < DEPTH + 2) begin
         step();
         n++;
      end
      check_eq("phase_reach", cyc % DEPTH, p);
   endtask

   task automatic start_walk(input int hx, input int hy, input int len, input int qx, input int qy);
      i_head_x = 4'(hx); i_head_y = 4'(hy); i_len = 8'(len);
      i_query_x = 4'(qx); i_query_y = 4'(qy);
      i_start = 1'b1;
      step();
      i_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_ph);
      bit seen = 0;
      int ph = -1;
      for (int n = 0; n < 3 * DEPTH && !seen; n++) begin
         step();
         if (o_done) begin seen = 1; ph = cyc % DEPTH; end
      end
      check_eq({tag, "_done_seen"}, 32'(seen), 1);
      if (seen) begin
         check_eq({tag, "_done_phase"}, ph, exp_ph);
         check_eq({tag, "_busy_at_done"}, o_busy, 0);
         step();
         check_eq({tag, "_done_pulse"}, o_done, 0);
      end
   endtask

   task automatic run_walk(input string tag, input int hx, input int hy, input int len,
                           input int qx, input int qy, input int exp_hit, input int exp_idx,
                           input int exp_ph, input int exp_oob);
      start_walk(hx, hy, len, qx, qy);
      check_eq({tag, "_busy"}, o_busy, 1);
`ifndef SNAKE_WALKER_WRAP_EN
      check_eq({tag, "_oob_clr"}, o_oob, 0);
`endif
      wait_done(tag, exp_ph);
      check_eq({tag, "_hit"}, o_hit, exp_hit);
      check_eq({tag, "_idx"}, o_hit_idx, exp_idx);
`ifndef SNAKE_WALKER_WRAP_EN
      check_eq({tag, "_oob"}, o_oob, exp_oob);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int dn;
      rst_n = 1'b0; i_start = 1'b0; i_wr = 1'b0; i_wr_dir = 2'd0;
      i_head_x = '0; i_head_y = '0; i_len = '0; i_query_x = '0; i_query_y = '0;
      fill_en = 1'b1; fill_val = 2'd0;
      step();
      fill_en = 1'b0;
      step();
      check_eq("rst_busy", o_busy, 0);
      check_eq("rst_done", o_done, 0);
      check_eq("rst_hit", o_hit, 0);
      check_eq("rst_idx", o_hit_idx, 0);
      check_eq("rst_recirc", o_dir, i_dir);
`ifndef SNAKE_WALKER_WRAP_EN
      check_eq("rst_oob", o_oob, 0);
`endif
      rst_n = 1'b1;

      run_walk("hit4", 2, 3, 4, 5, 3, 1, 3, 4, 0);
      run_walk("miss4", 2, 3, 4, 6, 3, 0, 0, 4, 0);

      // Two turn requests before phase 0: only the later value lands in segment 0.
      wait_phase(10);
      i_wr = 1'b1; i_wr_dir = 2'd3;
      step();
      i_wr_dir = 2'd1;
      step();
      i_wr = 1'b0;
      run_walk("turn_miss", 0, 0, 3, 0, 2, 0, 0, 3, 0);
      run_walk("turn_hit", 0, 0, 3, 0, 1, 1, 1, 3, 0);
      check_eq("ring_ones", count_val(2'd1), 1);
      check_eq("ring_threes", count_val(2'd3), 0);

      fill_ring(2'd1);
`ifdef SNAKE_WALKER_WRAP_EN
      run_walk("y_edge", 0, 13, 2, 0, 14, 0, 0, 2, 0);
`else
      run_walk("y_edge", 0, 13, 2, 0, 14, 1, 1, 2, 1);
`endif

      fill_ring(2'd2);
      run_walk("x_edge", 0, 5, 2, 15, 5, 1, 1, 2, 0);
      run_walk("len0", 7, 7, 0, 7, 7, 1, 0, 1, 0);
      run_walk("len_big", 0, 5, 255, 3, 5, 1, 13, 0, 0);

      wait_phase(10);
      start_walk(0, 5, 10, 12, 5);
      wait_phase(3);
      start_walk(9, 9, 1, 9, 9);
      wait_done("ignore", 10);
      check_eq("ignore_hit", o_hit, 1);
      check_eq("ignore_idx", o_hit_idx, 4);
      repeat (5) step();
      check_eq("ignore_idle", o_busy, 0);

      wait_phase(10);
      start_walk(0, 5, 50, 14, 5);
      wait_phase(5);
      check_eq("pre_rst_hit", o_hit, 1);
      rst_n = 1'b0;
      step();
      check_eq("mid_rst_busy", o_busy, 0);
      check_eq("mid_rst_done", o_done, 0);
      check_eq("mid_rst_hit", o_hit, 0);
      check_eq("mid_rst_idx", o_hit_idx, 0);
      check_eq("mid_rst_recirc", o_dir, i_dir);
      step();
      rst_n = 1'b1;
      dn = 0;
      for (int n = 0; n < DEPTH + 10; n++) begin
         step();
         if (o_done) dn++;
      end
      check_eq("post_rst_no_done", dn, 0);
      check_eq("post_rst_busy", o_busy, 0);
      check_eq("ring_kept", count_val(2'd2), DEPTH);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
